// File: rtl/stream_packer_pkg.sv
// Shared stream helpers: counter/index sizing used by the packer and the downsizer,
// plus the FIFO entry layout for the default 8x4 configuration.
package stream_packer_pkg;

  function automatic int cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  function automatic int idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  typedef struct packed {
    logic        last;
    logic [2:0]  count;
    logic [31:0] data;
  } pack_word_t;

endpackage

// File: rtl/stream_packer.sv
// Packs RATIO narrow beats into one wide word; w_last closes a partial word early.
// Outputs come straight from registers; only r_ready -> w_ready is combinational.
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int RATIO      = 4,
  localparam int CW         = cnt_w(RATIO)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [DATA_WIDTH-1:0]       w_data,
  input  logic                        w_last,
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [RATIO*DATA_WIDTH-1:0] r_data,
  output logic [CW-1:0]               r_count,
  output logic                        r_last
);

  localparam int IW = idx_w(RATIO);

  logic [RATIO-1:0][DATA_WIDTH-1:0] r_lanes, w_lanes_n;
  logic [CW-1:0]                    r_cnt, w_cnt_n, w_base;
  logic                             r_full, w_full_n;
  logic                             r_lst, w_lst_n;
  logic                             w_wfire, w_rfire;
  logic [IW-1:0]                    w_idx;

  assign w_ready = !r_full || r_ready;
  assign w_wfire = w_valid && w_ready;
  assign w_rfire = r_full && r_ready;

  always_comb begin
    w_lanes_n = r_lanes;
    w_cnt_n   = r_cnt;
    w_full_n  = r_full;
    w_lst_n   = r_lst;
    w_base    = r_cnt;
    w_idx     = '0;
    if (w_rfire) begin
      w_lanes_n = '0;
      w_cnt_n   = '0;
      w_full_n  = 1'b0;
      w_lst_n   = 1'b0;
      w_base    = '0;
    end
    // A beat arriving as the word leaves restarts filling at lane 0 with no bubble.
    if (w_wfire) begin
      w_idx            = w_base[IW-1:0];
      w_lanes_n[w_idx] = w_data;
      w_cnt_n          = w_base + CW'(1);
      if (w_cnt_n == CW'(RATIO) || w_last) begin
        w_full_n = 1'b1;
        w_lst_n  = w_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lanes <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_lst   <= 1'b0;
    end else begin
      r_lanes <= w_lanes_n;
      r_cnt   <= w_cnt_n;
      r_full  <= w_full_n;
      r_lst   <= w_lst_n;
    end
  end

  assign r_data  = r_lanes;
  assign r_count = r_cnt;
  assign r_valid = r_full;
  assign r_last  = r_lst;

endmodule

// File: tb/tb_stream_packer.sv
// Bench for stream_packer: RATIO=4 and RATIO=1 instances share stimulus, each checked
// every cycle against a queue-based word model, plus directed literal checks.
module tb_stream_packer;

  logic       clk = 1'b0, rst = 1'b1;
  logic       w_valid = 1'b0, w_last = 1'b0, r_ready = 1'b0;
  logic [7:0] w_data = '0;

  logic        w_ready0, r_valid0, r_last0;
  logic [31:0] r_data0;
  logic [2:0]  r_count0;
  logic        w_ready1, r_valid1, r_last1;
  logic [7:0]  r_data1;
  logic [0:0]  r_count1;

  int errors = 0, checks = 0;
  int nfire0 = 0;
  bit wr0_seen, wr1_seen;

  typedef struct {
    logic [31:0] d;
    int          c;
    bit          l;
  } word_t;

  word_t       q0[$], q1[$];
  logic [31:0] pd[2];
  int          pc[2];

  stream_packer #(.DATA_WIDTH(8), .RATIO(4)) u0 (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready0), .w_data(w_data),
    .w_last(w_last), .r_valid(r_valid0), .r_ready(r_ready), .r_data(r_data0),
    .r_count(r_count0), .r_last(r_last0));

  stream_packer #(.DATA_WIDTH(8), .RATIO(1)) u1 (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready1), .w_data(w_data),
    .w_last(w_last), .r_valid(r_valid1), .r_ready(r_ready), .r_data(r_data1),
    .r_count(r_count1), .r_last(r_last1));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic int rat(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic word_t qhead(input int k);
    if (k == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    pd[0] = '0; pd[1] = '0;
    pc[0] = 0;  pc[1] = 0;
  endtask

  // Accepted beats accumulate into a pending word; a full or w_last word becomes an expected output.
  task automatic model_step(input int k, input bit fw, input bit fr, input logic [7:0] d, input bit l);
    word_t w;
    if (fr) begin
      checks++;
      if (qsize(k) == 0) begin
        errors++;
        $display("FAIL u%0d_pop: output fired with no completed word in model", k);
      end else if (k == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end
    if (fw) begin
      pd[k] = pd[k] | (32'(d) << (8 * pc[k]));
      pc[k]++;
      if (pc[k] == rat(k) || l) begin
        w.d = pd[k]; w.c = pc[k]; w.l = l;
        if (k == 0) q0.push_back(w); else q1.push_back(w);
        pd[k] = '0;
        pc[k] = 0;
      end
    end
  endtask

  task automatic cmp(input int k, input logic v, input logic [31:0] d, input logic [31:0] c,
                     input logic l, input logic wr);
    word_t h;
    if (qsize(k) > 0) begin
      h = qhead(k);
      chk($sformatf("u%0d_valid", k), 32'(v), 32'd1);
      chk($sformatf("u%0d_data", k), d, h.d);
      chk($sformatf("u%0d_count", k), c, 32'(h.c));
      chk($sformatf("u%0d_last", k), 32'(l), 32'(h.l));
    end else begin
      chk($sformatf("u%0d_valid", k), 32'(v), 32'd0);
      chk($sformatf("u%0d_partial", k), d, pd[k]);
      chk($sformatf("u%0d_fill", k), c, 32'(pc[k]));
      chk($sformatf("u%0d_last", k), 32'(l), 32'd0);
    end
    chk($sformatf("u%0d_wready", k), 32'(wr), 32'(!v || r_ready));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp(0, r_valid0, r_data0, 32'(r_count0), r_last0, w_ready0);
      cmp(1, r_valid1, 32'(r_data1), 32'(r_count1), r_last1, w_ready1);
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit rr);
    bit fw0, fr0, fw1, fr1;
    w_valid = v; w_data = d; w_last = l; r_ready = rr;
    @(negedge clk);
    fw0 = w_valid && w_ready0; fr0 = r_valid0 && r_ready;
    fw1 = w_valid && w_ready1; fr1 = r_valid1 && r_ready;
    wr0_seen = w_ready0; wr1_seen = w_ready1;
    if (fr0) nfire0++;
    @(posedge clk);
    model_step(0, fw0, fr0, d, l);
    model_step(1, fw1, fr1, d, l);
    #1;
  endtask

  task automatic do_reset();
    w_valid = 1'b0; r_ready = 1'b0; w_last = 1'b0;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int base;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(r_valid0), 32'd0);
    chk("rst_data", r_data0, 32'd0);
    chk("rst_count", 32'(r_count0), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b1);
    chk("t1_valid", 32'(r_valid0), 32'd1);
    chk("t1_data", r_data0, 32'h44332211);
    chk("t1_count", 32'(r_count0), 32'd4);
    chk("t1_last", 32'(r_last0), 32'd0);

    cyc(1'b1, 8'hAA, 1'b0, 1'b1);
    cyc(1'b1, 8'hBB, 1'b1, 1'b1);
    chk("t2_data", r_data0, 32'h0000BBAA);
    chk("t2_count", 32'(r_count0), 32'd2);
    chk("t2_last", 32'(r_last0), 32'd1);
    cyc(1'b1, 8'hCC, 1'b0, 1'b1);
    chk("t2_next_valid", 32'(r_valid0), 32'd0);
    chk("t2_next_data", r_data0, 32'h000000CC);
    chk("t2_next_count", 32'(r_count0), 32'd1);

    do_reset();
    base = nfire0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 8'(i + 1), 1'b0, 1'b1);
      chk("t3_wready", 32'(wr0_seen), 32'd1);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_words", 32'(nfire0 - base), 32'd3);

    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h55, 1'b0, 1'b0);
      chk("t4_wready", 32'(wr0_seen), 32'd0);
      chk("t4_hold", r_data0, 32'h44332211);
    end
    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    chk("t4_lane0", r_data0, 32'h00000055);
    chk("t4_count", 32'(r_count0), 32'd1);
    chk("t4_valid", 32'(r_valid0), 32'd0);

    do_reset();
    cyc(1'b1, 8'hE1, 1'b0, 1'b1);
    cyc(1'b1, 8'hE2, 1'b0, 1'b1);
    w_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_valid", 32'(r_valid0), 32'd0);
    chk("t5_data", r_data0, 32'd0);
    chk("t5_count", 32'(r_count0), 32'd0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b1);
    chk("t5_word", r_data0, 32'h04030201);

    do_reset();
    cyc(1'b1, 8'h5A, 1'b0, 1'b1);
    chk("t6_valid", 32'(r_valid1), 32'd1);
    chk("t6_data_a", 32'(r_data1), 32'h5A);
    chk("t6_count", 32'(r_count1), 32'd1);
    cyc(1'b1, 8'h5B, 1'b0, 1'b0);
    chk("t6_stall", 32'(wr1_seen), 32'd0);
    chk("t6_hold", 32'(r_data1), 32'h5A);
    cyc(1'b1, 8'h5B, 1'b0, 1'b1);
    chk("t6_data_b", 32'(r_data1), 32'h5B);

    do_reset();
    repeat (3000)
      cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 9) < 7));
    repeat (8) cyc(1'b0, 8'h00, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
